// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmit controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_tx_pkg;

    // Frame phases in transmission order
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Line level while no frame is in progress (mux a0 is tied to this)
    localparam logic IDLE_LEVEL  = 1'b1;
    // Line level of the start bit
    localparam logic START_LEVEL = 1'b0;

    // Number of bit periods in one frame for a given configuration
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits);
        return 1 + data_bits + ((parity_en != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage : uart_tx_pkg

// File: rtl/uart_tx_ctrl_baud.sv
// Bit-period timer: free-running 0..CLKS_PER_BIT-1 counter with terminal tick.
// Latency: tick is combinational on the registered count; clr takes effect next edge.
// Backpressure: none; clr holds the count at 0 for as long as it is asserted.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == TERM_CNT);
    assign tick   = w_term;

    // Count one bit period; wrap on terminal count, restart on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : baud_tick_gen

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte, serialises start/data/parity/stop onto tx_bit.
// Latency: START appears the cycle after accept; tx_done pulses the cycle after the last stop bit.
// Backpressure: tx_ready low for the whole frame; tx_valid/tx_data are ignored while busy.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_sel,
    output logic                 tx_bit,
    output logic                 tx_done
);

    localparam int unsigned BC_W = $clog2(DATA_BITS + 1);
    localparam logic [BC_W-1:0] LAST_DATA = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0] LAST_STOP = BC_W'(STOP_BITS - 1);
    localparam logic            PAR_ODD   = (PARITY_ODD != 0);
    localparam bit              HAS_PAR   = (PARITY_EN != 0);

    // Registered state and outputs
    tx_state_e            r_state;
    logic [DATA_BITS-1:0] r_sreg;
    logic [BC_W-1:0]      r_bitcnt;
    logic                 r_parity;
    logic                 r_tx_ready;
    logic                 r_tx_sel;
    logic                 r_tx_bit;
    logic                 r_tx_done;

    // Next-state values
    tx_state_e            w_nxt_state;
    logic [DATA_BITS-1:0] w_nxt_sreg;
    logic [BC_W-1:0]      w_nxt_bitcnt;
    logic                 w_nxt_parity;
    logic                 w_nxt_ready;
    logic                 w_nxt_sel;
    logic                 w_nxt_bit;
    logic                 w_nxt_done;

    logic                 w_accept;
    logic                 w_tick;
    logic                 w_baud_clr;

    assign w_accept   = (r_state == IDLE) && r_tx_ready && tx_valid;
    // Holding the timer cleared while idle makes it start at 0 on the cycle after accept
    assign w_baud_clr = (r_state == IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_baud_clr),
        .tick (w_tick)
    );

    // State, shift register, counters and outputs all update together at bit boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sreg     <= '0;
            r_bitcnt   <= '0;
            r_parity   <= 1'b0;
            r_tx_ready <= 1'b1;
            r_tx_sel   <= 1'b0;
            r_tx_bit   <= IDLE_LEVEL;
            r_tx_done  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_sreg     <= w_nxt_sreg;
            r_bitcnt   <= w_nxt_bitcnt;
            r_parity   <= w_nxt_parity;
            r_tx_ready <= w_nxt_ready;
            r_tx_sel   <= w_nxt_sel;
            r_tx_bit   <= w_nxt_bit;
            r_tx_done  <= w_nxt_done;
        end
    end

    // Frame sequencing; the line value for the next bit period is decided here so tx_bit is a flop
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_sreg   = r_sreg;
        w_nxt_bitcnt = r_bitcnt;
        w_nxt_parity = r_parity;
        w_nxt_ready  = r_tx_ready;
        w_nxt_sel    = r_tx_sel;
        w_nxt_bit    = r_tx_bit;
        w_nxt_done   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nxt_state  = START;
                    w_nxt_sreg   = tx_data;
                    // Parity is fixed at accept time so later shifting cannot disturb it
                    w_nxt_parity = (^tx_data) ^ PAR_ODD;
                    w_nxt_bitcnt = '0;
                    w_nxt_ready  = 1'b0;
                    w_nxt_sel    = 1'b1;
                    w_nxt_bit    = START_LEVEL;
                end
            end

            START: begin
                if (w_tick) begin
                    w_nxt_state  = DATA;
                    w_nxt_bit    = r_sreg[0];
                    w_nxt_sreg   = r_sreg >> 1;
                    w_nxt_bitcnt = '0;
                end
            end

            DATA: begin
                if (w_tick) begin
                    if (r_bitcnt == LAST_DATA) begin
                        w_nxt_bitcnt = '0;
                        if (HAS_PAR) begin
                            w_nxt_state = PARITY;
                            w_nxt_bit   = r_parity;
                        end else begin
                            w_nxt_state = STOP;
                            w_nxt_bit   = IDLE_LEVEL;
                        end
                    end else begin
                        w_nxt_bitcnt = r_bitcnt + 1'b1;
                        w_nxt_bit    = r_sreg[0];
                        w_nxt_sreg   = r_sreg >> 1;
                    end
                end
            end

            PARITY: begin
                if (w_tick) begin
                    w_nxt_state  = STOP;
                    w_nxt_bit    = IDLE_LEVEL;
                    w_nxt_bitcnt = '0;
                end
            end

            STOP: begin
                if (w_tick) begin
                    // Bit counter is reused here to count stop-bit periods
                    if (r_bitcnt == LAST_STOP) begin
                        w_nxt_state  = IDLE;
                        w_nxt_bitcnt = '0;
                        w_nxt_ready  = 1'b1;
                        w_nxt_sel    = 1'b0;
                        w_nxt_bit    = IDLE_LEVEL;
                        w_nxt_done   = 1'b1;
                    end else begin
                        w_nxt_bitcnt = r_bitcnt + 1'b1;
                    end
                end
            end

            default: begin
                w_nxt_state  = IDLE;
                w_nxt_bitcnt = '0;
                w_nxt_ready  = 1'b1;
                w_nxt_sel    = 1'b0;
                w_nxt_bit    = IDLE_LEVEL;
            end
        endcase
    end

    assign tx_ready = r_tx_ready;
    assign tx_sel   = r_tx_sel;
    assign tx_bit   = r_tx_bit;
    assign tx_done  = r_tx_done;

endmodule : uart_tx_ctrl

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four instances covering plain, even/odd parity and two stop bits.
// Each frame is compared cycle by cycle against a bit list built from the frame format.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_ctrl;

    localparam int CPB  = 4;
    localparam int NDUT = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] dat [NDUT];
    logic [NDUT-1:0] vld;
    logic [NDUT-1:0] rdy;
    logic [NDUT-1:0] sel;
    logic [NDUT-1:0] txb;
    logic [NDUT-1:0] done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instance configuration: 0 plain, 1 even parity, 2 odd parity, 3 two stop bits
    function automatic int cfg_pe(input int d);
        return (d == 1 || d == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_po(input int d);
        return (d == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_sb(input int d);
        return (d == 3) ? 2 : 1;
    endfunction

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx_sel(sel[0]), .tx_bit(txb[0]), .tx_done(done[0]));
    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx_sel(sel[1]), .tx_bit(txb[1]), .tx_done(done[1]));
    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx_sel(sel[2]), .tx_bit(txb[2]), .tx_done(done[2]));
    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[3]), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .tx_sel(sel[3]), .tx_bit(txb[3]), .tx_done(done[3]));

    // Reference: list of line levels for one frame, one entry per bit period
    task automatic build_exp(input int d, input logic [7:0] data,
                             output int nbits, output logic [15:0] line);
        int n;
        line = '1;
        n = 0;
        line[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            line[n] = data[i];
            n++;
        end
        if (cfg_pe(d) != 0) begin
            line[n] = ((^data) != (cfg_po(d) != 0));
            n++;
        end
        for (int s = 0; s < cfg_sb(d); s++) begin
            line[n] = 1'b1;
            n++;
        end
        nbits = n;
    endtask

    // Sends one frame on instance d and checks every cycle of it plus the done cycle.
    // presented: the byte was already put on tx_valid/tx_data during the previous done cycle.
    // chain: keep tx_valid high through the frame and offer nxt during the done cycle.
    task automatic run_frame(input int d, input logic [7:0] data, input bit presented,
                             input bit chain, input logic [7:0] nxt);
        int          nb;
        int          len;
        logic [15:0] line;
        logic        want;
        build_exp(d, data, nb, line);
        len = nb * CPB;
        if (!presented) begin
            @(negedge clk);
            total++;
            if ({rdy[d], sel[d]} !== 2'b10) begin
                bad++;
                $display("FAIL idle_before d%0d: rdy/sel=%b required 10", d, {rdy[d], sel[d]});
            end
            dat[d] = data;
            vld[d] = 1'b1;
        end
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            want = line[(k - 1) / CPB];
            total++;
            if ({rdy[d], sel[d], txb[d], done[d]} !== {1'b0, 1'b1, want, 1'b0}) begin
                bad++;
                $display("FAIL frame d%0d data=%h cyc%0d: rdy/sel/bit/done=%b required %b",
                         d, data, k, {rdy[d], sel[d], txb[d], done[d]}, {1'b0, 1'b1, want, 1'b0});
            end
            vld[d] = chain;
            dat[d] = 8'($urandom);
        end
        @(negedge clk);
        total++;
        if ({rdy[d], sel[d], txb[d], done[d]} !== 4'b1011) begin
            bad++;
            $display("FAIL done d%0d data=%h cyc%0d: rdy/sel/bit/done=%b required 1011",
                     d, data, len + 1, {rdy[d], sel[d], txb[d], done[d]});
        end
        if (chain) begin
            dat[d] = nxt;
            vld[d] = 1'b1;
        end else begin
            vld[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++;
        if ({rdy, sel, txb, done} !== {4'hF, 4'h0, 4'hF, 4'h0}) begin
            bad++;
            $display("FAIL reset_values: rdy=%b sel=%b bit=%b done=%b required 1111 0000 1111 0000",
                     rdy, sel, txb, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            total++;
            if ({rdy, sel, txb, done} !== {4'hF, 4'h0, 4'hF, 4'h0}) begin
                bad++;
                $display("FAIL idle_hold cyc%0d: rdy=%b sel=%b bit=%b done=%b", c, rdy, sel, txb, done);
            end
        end
    endtask

    task automatic test_basic();
        run_frame(0, 8'hA5, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_parity();
        run_frame(1, 8'h07, 1'b0, 1'b0, 8'h00);
        run_frame(2, 8'h07, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        run_frame(0, 8'h55, 1'b0, 1'b1, 8'hF0);
        run_frame(0, 8'hF0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        dat[0] = 8'hFF;
        vld[0] = 1'b1;
        // START occupies cycles 1..4, data bit n occupies 5+4n..8+4n; stop inside bit 3
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            vld[0] = 1'b0;
        end
        total++;
        if ({sel[0], rdy[0]} !== 2'b10) begin
            bad++;
            $display("FAIL midframe_busy: sel/rdy=%b required 10", {sel[0], rdy[0]});
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rdy[0], sel[0], txb[0], done[0]} !== 4'b1010) begin
            bad++;
            $display("FAIL async_abort: rdy/sel/bit/done=%b required 1010",
                     {rdy[0], sel[0], txb[0], done[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 8'h01, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_stop2();
        run_frame(3, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] cur;
        logic [7:0] nxt;
        bit         pres;
        bit         ch;
        for (int d = 0; d < NDUT; d++) begin
            pres = 1'b0;
            cur  = 8'($urandom);
            for (int i = 0; i < 6; i++) begin
                ch  = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
                nxt = 8'($urandom);
                run_frame(d, cur, pres, ch, nxt);
                pres = ch;
                cur  = ch ? nxt : 8'($urandom);
            end
        end
    endtask

    initial begin
        vld = '0;
        for (int d = 0; d < NDUT; d++) dat[d] = 8'h00;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_reset_midframe();
        test_stop2();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_tx_ctrl
